popcount_window_acc: RTL

Streaming downstream consumer of the popcount adder tree. It accepts data beats over a valid/ready handshake and takes each beat's Hamming weight from one popcount instance. It sums the weights over a window and presents the total and the beat count over a second valid/ready handshake. A window closes on in_last_i or after MAX_BEATS accepted beats. Typical users are bit-error counters and sparsity or activity monitors.

---
 rtl/popcount_window_pkg.sv | 22 ++
 rtl/popcount.sv | 24 ++
 rtl/popcount_window_acc.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/popcount_window_pkg.sv
// Purpose : shared types and sizing helpers for the popcount window accumulator.
// Latency : n/a (package only).
// Backpressure: n/a (package only).
//
// Contents:
//   state_e   - window controller states (IDLE, ACC, HOLD)
//   cnt_width - width needed to hold DATA_WIDTH*MAX_BEATS without overflow;
//               parents use it to size wires attached to out_count_o.
package popcount_window_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_e;

  function automatic int unsigned cnt_width(input int unsigned data_width,
                                            input int unsigned max_beats);
    return $clog2(data_width * max_beats + 1);
  endfunction

endpackage

// File: rtl/popcount.sv
// Purpose : combinational Hamming weight of one INPUT_WIDTH-bit word.
// Latency : 0 cycles (pure combinational).
// Backpressure: none (no handshake).
//
// Ports:
//   data_i  [INPUT_WIDTH-1:0]        word to count
//   count_o [$clog2(INPUT_WIDTH):0]  number of set bits in data_i
module popcount #(
  parameter  int unsigned INPUT_WIDTH = 2,
  localparam int unsigned OUT_WIDTH   = $clog2(INPUT_WIDTH) + 1
) (
  input  logic [INPUT_WIDTH-1:0] data_i,
  output logic [OUT_WIDTH-1:0]   count_o
);

  // A linear sum is written here; synthesis rebalances it into an adder tree.
  always_comb begin
    count_o = '0;
    for (int i = 0; i < int'(INPUT_WIDTH); i++) begin
      count_o = count_o + OUT_WIDTH'(data_i[i]);
    end
  end

endmodule

// File: rtl/popcount_window_acc.sv
// Purpose : sums per-beat popcounts over a window closed by in_last_i or MAX_BEATS beats.
// Latency : closing beat accepted in cycle t -> out_valid_o in t+1 (t+2 with the pipe stage).
// Backpressure: in_ready_o drops while a result is held (and while clear_i or a closing beat sits in the pipe).
//
// Optional build macro: POPCOUNT_WINDOW_ACC_PIPE_EN inserts a register stage
// (popcount, close flag, last flag, valid) between the popcount and the accumulator.
//
// Ports:
//   clk_i, rst_ni                       clock, asynchronous active-low reset
//   clear_i                             synchronous abort of window and held result
//   in_valid_i/in_ready_o/in_data_i/in_last_i   input beat handshake
//   out_valid_o/out_ready_i             result handshake
//   out_count_o                         total ones in the window
//   out_beats_o                         accepted beats in the window
//   out_last_o                          1 = closed by in_last_i, 0 = closed by MAX_BEATS
module popcount_window_acc
  import popcount_window_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH = 64,
  parameter  int unsigned MAX_BEATS  = 256,
  localparam int unsigned CNT_WIDTH  = cnt_width(DATA_WIDTH, MAX_BEATS),
  localparam int unsigned BEAT_WIDTH = $clog2(MAX_BEATS + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  input  logic                  in_last_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [CNT_WIDTH-1:0]  out_count_o,
  output logic [BEAT_WIDTH-1:0] out_beats_o,
  output logic                  out_last_o
);

  localparam int unsigned PC_WIDTH = $clog2(DATA_WIDTH) + 1;

  logic [PC_WIDTH-1:0] pc;

  popcount #(
    .INPUT_WIDTH (DATA_WIDTH)
  ) u_popcount (
    .data_i  (in_data_i),
    .count_o (pc)
  );

  state_e                state_q, state_d;
  logic [CNT_WIDTH-1:0]  acc_q, acc_d;
  logic [BEAT_WIDTH-1:0] beats_q, beats_d;
  logic [CNT_WIDTH-1:0]  out_count_q, out_count_d;
  logic [BEAT_WIDTH-1:0] out_beats_q, out_beats_d;
  logic                  out_last_q, out_last_d;

  logic                  in_ready;
  logic                  accept;
  logic                  pipe_block;
  logic [BEAT_WIDTH-1:0] beats_inc;
  logic                  beat_closes;

  // Back-end view of a beat: the beat that is added to the accumulator this
  // cycle. Without the pipe stage it is the beat being accepted; with it, the
  // beat accepted one cycle earlier.
  logic                  bk_vld;
  logic [CNT_WIDTH-1:0]  bk_cnt;
  logic                  bk_close;
  logic                  bk_last;
  logic [BEAT_WIDTH-1:0] bk_beats;

  // beats_q counts accepted beats at the input side, so the MAX_BEATS close
  // is decided on the accepting edge in both builds.
  assign beats_inc   = beats_q + BEAT_WIDTH'(1);
  assign beat_closes = in_last_i || (beats_inc == BEAT_WIDTH'(MAX_BEATS));
  assign accept      = in_valid_i && in_ready;

`ifdef POPCOUNT_WINDOW_ACC_PIPE_EN
  logic                p_vld_q, p_vld_d;
  logic [PC_WIDTH-1:0] p_cnt_q, p_cnt_d;
  logic                p_close_q, p_close_d;
  logic                p_last_q, p_last_d;

  always_comb begin
    p_vld_d   = accept;
    p_cnt_d   = pc;
    p_close_d = accept && beat_closes;
    p_last_d  = in_last_i;
    if (clear_i) begin
      p_vld_d   = 1'b0;
      p_close_d = 1'b0;
      p_last_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      p_vld_q   <= 1'b0;
      p_cnt_q   <= '0;
      p_close_q <= 1'b0;
      p_last_q  <= 1'b0;
    end else begin
      p_vld_q   <= p_vld_d;
      p_cnt_q   <= p_cnt_d;
      p_close_q <= p_close_d;
      p_last_q  <= p_last_d;
    end
  end

  // A closing beat in the pipe must not be followed by the next window's
  // first beat before the result has been loaded.
  assign pipe_block = p_vld_q && p_close_q;
  assign bk_vld     = p_vld_q;
  assign bk_cnt     = CNT_WIDTH'(p_cnt_q);
  assign bk_close   = p_close_q;
  assign bk_last    = p_last_q;
  // beats_q already includes the closing beat (it was counted when accepted).
  assign bk_beats   = beats_q;
`else
  assign pipe_block = 1'b0;
  assign bk_vld     = accept;
  assign bk_cnt     = CNT_WIDTH'(pc);
  assign bk_close   = beat_closes;
  assign bk_last    = in_last_i;
  assign bk_beats   = beats_inc;
`endif

  // Ready is independent of in_valid_i; clear_i blocks acceptance outright.
  assign in_ready = (state_q != HOLD) && !pipe_block && !clear_i;

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, ACC: begin
        if (bk_vld && bk_close) begin
          state_d = HOLD;
        end else if (accept) begin
          state_d = ACC;
        end
      end
      HOLD: begin
        if (out_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (clear_i) begin
      state_d = IDLE;
    end
  end

  // Accumulator, beat counter and result registers.
  always_comb begin
    acc_d       = acc_q;
    beats_d     = beats_q;
    out_count_d = out_count_q;
    out_beats_d = out_beats_q;
    out_last_d  = out_last_q;

    if (accept) begin
      beats_d = beats_inc;
    end
    if (bk_vld) begin
      acc_d = acc_q + bk_cnt;
    end
    if (bk_vld && bk_close) begin
      out_count_d = acc_q + bk_cnt;
      out_beats_d = bk_beats;
      out_last_d  = bk_last;
      acc_d       = '0;
      beats_d     = '0;
    end

    if (clear_i) begin
      acc_d       = '0;
      beats_d     = '0;
      out_count_d = '0;
      out_beats_d = '0;
      out_last_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      beats_q     <= '0;
      out_count_q <= '0;
      out_beats_q <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      beats_q     <= beats_d;
      out_count_q <= out_count_d;
      out_beats_q <= out_beats_d;
      out_last_q  <= out_last_d;
    end
  end

  assign in_ready_o  = in_ready;
  assign out_valid_o = (state_q == HOLD);
  assign out_count_o = out_count_q;
  assign out_beats_o = out_beats_q;
  assign out_last_o  = out_last_q;

endmodule
